nibble_serial_sub16: RTL
========================

NIBBLE_SERIAL_SUB16 -- requirements
Module: nibble_serial_sub16

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits. It SHALL be a non-zero multiple of 4; other values are unsupported.
REQ-002 The block SHALL have exactly one clock and one reset. Reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 Start  input  1  request pulse; sampled on the rising clk edge.
REQ-006 A  input  WIDTH  minuend; sampled with Start.
REQ-007 B  input  WIDTH  subtrahend; sampled with Start.
REQ-008 Bin  input  1  borrow-in; sampled with Start.
REQ-009 Busy  output  1  high while a subtraction is in progress.
REQ-010 Done  output  1  one-cycle pulse marking that the result is valid.
REQ-011 Diff  output  WIDTH  result, A - B - Bin, modulo 2^WIDTH.
REQ-012 Bout  output  1  borrow-out: 1 when unsigned A < B + Bin.
REQ-013 Zero  output  1  Diff == 0; present only with SUB_FLAGS_EN.
REQ-014 Ovf  output  1  two's-complement signed overflow; present only with SUB_FLAGS_EN.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE -> RUN on an edge where Start=1. On that edge the block SHALL latch A, B and Bin into internal registers and load the nibble counter with 0.
REQ-017 Start SHALL be ignored in RUN and in DONE; the latched operands SHALL stay unchanged.
REQ-018 In RUN, each edge SHALL process one nibble, starting with the least significant:
- compute the 4-bit value opA - opB - borrow;
- shift the 4-bit result into Diff from the MSB side;
- right-shift the operand registers by 4;
- register the nibble's borrow-out as the next borrow.
REQ-019 After WIDTH/4 nibble edges, RUN -> DONE. On that same edge Done SHALL go to 1, Diff SHALL be final, and Bout SHALL equal the final borrow.
REQ-020 Latency with WIDTH=16: Start sampled at edge N; Done is high from edge N+5 to edge N+6, exactly one cycle.
REQ-021 DONE -> IDLE unconditionally on the next edge; Done returns to 0.
REQ-022 Busy SHALL be 1 exactly in RUN and DONE, and 0 in IDLE.
REQ-023 Diff and Bout SHALL update only on the last RUN edge. They SHALL hold their values until the next completion or reset.
REQ-024 The intermediate shifting of Diff SHALL use an internal register; the Diff output SHALL never show a partial result.
REQ-025 Borrow chaining across nibbles SHALL make the result identical to a single full-width ripple subtraction.

Reset
REQ-026 While rst_n=0, regardless of clk:
- state = IDLE;
- Busy = 0, Done = 0, Diff = 0, Bout = 0, Zero = 0, Ovf = 0;
- counter, operand and borrow registers = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation. Done SHALL NOT pulse for the aborted operation.
REQ-028 After rst_n deasserts, the first rising edge with Start=1 SHALL be accepted normally.

Configuration
REQ-029 Macro SUB_FLAGS_EN. When defined:
- ports Zero and Ovf exist;
- both SHALL update on the same edge as Diff and hold with it;
- Zero = (Diff == 0);
- Ovf = (A[WIDTH-1] != B[WIDTH-1]) && (Diff[WIDTH-1] != A[WIDTH-1]), using the latched A and B.
REQ-030 When SUB_FLAGS_EN is undefined, the Zero and Ovf ports and their logic SHALL be absent. All other behaviour SHALL be identical.

Verification (WIDTH=16)
REQ-031 A=0x1234, B=0x0234, Bin=0, Start pulsed at edge N -> Busy high from N; Done high only in the cycle after edge N+5; Diff=0x1000, Bout=0.
REQ-032 A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1; with SUB_FLAGS_EN, Zero=0 and Ovf=0.
REQ-033 Flags build: A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, Ovf=1. Then A=0x5555, B=0x5554, Bin=1 -> Diff=0x0000, Zero=1, Bout=0.
REQ-034 Start with A=0x0010, B=0x0001; at edge N+2, pulse Start again with A=0xFFFF, B=0x0000 -> the second Start is ignored; Diff=0x000F; exactly one Done pulse.
REQ-035 Start with A=0x1234, B=0x0234; drive rst_n=0 between edges N+2 and N+3 -> all outputs 0 immediately and no Done pulse. Then start A=0x0003, B=0x0001, Bin=1 -> Diff=0x0001, Bout=0.

Source files
------------

// File: rtl/nibble_serial_sub16.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub16
//
// Computes Diff = A - B - Bin (mod 2^WIDTH) one nibble per clock, starting
// with the least significant nibble. The borrow out of each nibble feeds the
// next nibble, so the result matches a full-width ripple subtraction.
// A request is accepted in IDLE when Start is high. The operands are latched
// and the FSM moves to RUN. RUN spends WIDTH/4 edges processing nibbles and
// one more edge committing the result. The FSM then moves to DONE for one
// cycle and returns to IDLE.
//
// Optional feature macro: SUB_FLAGS_EN. When it is defined, the Zero and Ovf
// flag ports and their logic are present.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   Start  in   request pulse, sampled only in IDLE
//   A      in   minuend (WIDTH bits), latched with Start
//   B      in   subtrahend (WIDTH bits), latched with Start
//   Bin    in   borrow-in, latched with Start
//   Busy   out  high in RUN and DONE
//   Done   out  one-cycle pulse while the result is fresh
//   Diff   out  A - B - Bin, updated only on completion
//   Bout   out  final borrow (unsigned A < B + Bin)
//   Zero   out  Diff == 0                 (SUB_FLAGS_EN only)
//   Ovf    out  signed two's-complement overflow (SUB_FLAGS_EN only)
// -----------------------------------------------------------------------------
module nibble_serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [4:0]       nibDiff;
  logic             nibblesDone;
`ifdef SUB_FLAGS_EN
  logic             signA_q, signA_d;
  logic             signB_q, signB_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // The count reaches NIB once every nibble has been shifted in. The RUN edge
  // after that commits the result.
  assign nibblesDone = (cnt_q == CW'(NIB));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (Start) state_d = RUN;
      RUN:  if (nibblesDone) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: Done is exactly the DONE state, so it lasts one cycle.
  always_comb begin
    Busy = (state_q != IDLE);
    Done = (state_q == DONE);
    Diff = diff_q;
    Bout = bout_q;
`ifdef SUB_FLAGS_EN
    Zero = zero_q;
    Ovf  = ovf_q;
`endif
  end

  // One nibble of subtraction. With 5-bit arithmetic, bit 4 is set exactly
  // when the 4-bit result went negative, which is the nibble's borrow-out.
  always_comb begin
    nibDiff = {1'b0, opA_q[3:0]} - {1'b0, opB_q[3:0]} - {4'b0000, borrow_q};
  end

  // Datapath next-state. Partial results build up in shift_q and reach
  // diff_q only on the commit edge, so Diff never shows a partial result.
  always_comb begin
    cnt_d    = cnt_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    shift_d  = shift_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SUB_FLAGS_EN
    signA_d  = signA_q;
    signB_d  = signB_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          opA_d    = A;
          opB_d    = B;
          borrow_d = Bin;
          cnt_d    = '0;
          shift_d  = '0;
`ifdef SUB_FLAGS_EN
          signA_d  = A[WIDTH-1];
          signB_d  = B[WIDTH-1];
`endif
        end
      end
      RUN: begin
        if (!nibblesDone) begin
          opA_d    = opA_q >> 4;
          opB_d    = opB_q >> 4;
          shift_d  = shift_q >> 4;
          shift_d[WIDTH-1 -: 4] = nibDiff[3:0];
          borrow_d = nibDiff[4];
          cnt_d    = cnt_q + 1'b1;
        end else begin
          diff_d = shift_q;
          bout_d = borrow_q;
`ifdef SUB_FLAGS_EN
          // The operand registers have been shifted away by now, so the
          // overflow check uses the sign bits saved at Start.
          zero_d = (shift_q == '0);
          ovf_d  = (signA_q != signB_q) && (shift_q[WIDTH-1] != signA_q);
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      shift_q  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
`ifdef SUB_FLAGS_EN
      signA_q  <= 1'b0;
      signB_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      shift_q  <= shift_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
`ifdef SUB_FLAGS_EN
      signA_q  <= signA_d;
      signB_q  <= signB_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule
